memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single 32-bit memory port between instruction fetch and load/store.
//  Captures one-cycle request pulses from each side and issues them one at a time.
//  Routes each response back to its owner.
//  Data has priority; a streak limit guarantees fetch forward progress.
// PARAMETERS
//  MAX_STREAK  4  consecutive data grants allowed while a fetch waits (>=1)
// PORTS
//  clock       in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-low reset
//  imem_valid  in   1   fetch request pulse (one cycle)
//  imem_addr   in   32  fetch address
//  imem_ready  out  1   fetch response pulse
//  imem_rdata  out  32  fetch data, valid with imem_ready
//  dmem_valid  in   1   load/store request pulse (one cycle)
//  dmem_addr   in   32  data address
//  dmem_wdata  in   32  store data
//  dmem_wstrb  in   4   byte strobes; 0000 = load
//  dmem_ready  out  1   data response pulse
//  dmem_rdata  out  32  load data, valid with dmem_ready
//  mem_valid   out  1   memory request pulse (registered)
//  mem_instr   out  1   1 = current request is a fetch
//  mem_addr    out  32  request address (registered)
//  mem_wdata   out  32  store data (registered)
//  mem_wstrb   out  4   strobes (registered); 0 for fetch
//  mem_ready   in   1   memory response pulse, earliest 1 cycle after mem_valid
//  mem_rdata   in   32  memory read data
//  proto_err   out  1   sticky: request pulse seen while same port outstanding
// BEHAVIOUR
//  Reset values
//   - All outputs 0, pending flags 0, state IDLE, streak 0.
//  Capture
//   - x_valid loads a per-port pending buffer (addr/wdata/wstrb).
//   - The port is outstanding from its valid pulse to its ready pulse.
//   - A pulse while that port is outstanding is dropped and sets proto_err.
//   - A pulse in the same cycle as that port's ready is legal and captured.
//  States
//   - IDLE: no pending request -> stay in IDLE.
//   - IDLE: a pending request exists -> grant it, drive mem_valid=1 for exactly one cycle,
//     and go to BUSY_I or BUSY_D.
//   - BUSY_x: wait for mem_ready, then go to IDLE. The next grant comes no earlier than the following cycle.
//  Latency
//   - Pulse at cycle T with arbiter idle -> mem_valid at T+1.
//   - Pulse arriving during IDLE's grant cycle waits for the next IDLE.
//  Priority
//   - Data wins when both ports are pending.
//   - streak counts data grants issued while a fetch is pending.
//   - Exception: if streak==MAX_STREAK, the fetch wins.
//   - streak clears on any fetch grant or when no fetch is pending. It saturates and never wraps.
//  Response
//   - imem_ready = mem_ready & BUSY_I; dmem_ready = mem_ready & BUSY_D (combinational).
//   - rdata outputs = mem_rdata.
//   - mem_ready in IDLE is ignored (stale response after reset).
//  Reset mid-transaction
//   - Async reset clears state and all pending requests; nothing is replayed.
//  Width rules
//   - No arithmetic on addr/data; they pass through unchanged.
//   - streak width = $clog2(MAX_STREAK+1).
// TESTING
//  - Fetch 0x00000100 alone; memory replies after 2 cycles with 0x00000013.
//    -> mem_valid at T+1, mem_instr=1, imem_ready with rdata 0x13, dmem_ready stays 0.
//  - Fetch and store (0x2000, 0xDEADBEEF, 1111) in the same cycle.
//    -> store granted first (mem_instr=0), fetch granted in the cycle after store's mem_ready.
//  - Fetch held pending, data pulses re-issued after every dmem_ready, MAX_STREAK=4.
//    -> exactly 4 data grants, then the fetch; streak back to 0.
//  - Second dmem_valid while the data port is outstanding.
//    -> request dropped, proto_err=1 and stays 1, first transaction completes normally.
//  - Assert reset during BUSY_D, then release; memory raises mem_ready later.
//    -> all outputs 0, mem_ready ignored, no dmem_ready.
//  - New imem_valid in the same cycle as imem_ready.
//    -> captured, granted, proto_err stays 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one 32-bit memory port between instruction fetch and
// load/store. Each side sends one-cycle request pulses; the arbiter buffers them,
// issues one memory request at a time, and routes the response back to its owner.
// Data has priority, and a streak limit stops data traffic from starving fetch.
module memory_arbiter #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int unsigned SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } state_t;

    state_t state_q, state_d;

    // Per-port pending buffers
    logic        pend_i_q, pend_i_d;
    logic [31:0] pend_i_addr_q, pend_i_addr_d;
    logic        pend_d_q, pend_d_d;
    logic [31:0] pend_d_addr_q, pend_d_addr_d;
    logic [31:0] pend_d_wdata_q, pend_d_wdata_d;
    logic [3:0]  pend_d_wstrb_q, pend_d_wstrb_d;

    // Outstanding tracking (valid pulse up to ready pulse) and error flag
    logic        out_i_q, out_i_d;
    logic        out_d_q, out_d_d;
    logic        proto_err_q, proto_err_d;

    logic [SW-1:0] streak_q, streak_d;

    // Registered memory request
    logic        mem_valid_q, mem_valid_d;
    logic        mem_instr_q, mem_instr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    logic accept_i, accept_d, drop_i, drop_d;
    logic any_pend, cand_i, cand_d, streak_full, is_idle;
    logic grant_i, grant_d, direct_i, direct_d;
    logic [31:0] sel_i_addr, sel_d_addr, sel_d_wdata;
    logic [3:0]  sel_d_wstrb;

    // Responses are routed purely by which transaction is in flight.
    assign imem_ready = mem_ready & (state_q == StBusyI);
    assign dmem_ready = mem_ready & (state_q == StBusyD);
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign proto_err = proto_err_q;

    // A pulse is legal when the port is free or is completing this very cycle.
    assign accept_i = imem_valid & (~out_i_q | imem_ready);
    assign accept_d = dmem_valid & (~out_d_q | dmem_ready);
    assign drop_i   = imem_valid & ~accept_i;
    assign drop_d   = dmem_valid & ~accept_d;

    // Buffered requests take precedence; a fresh pulse only competes when
    // nothing is buffered, so pulses arriving in a grant cycle wait their turn.
    assign any_pend    = pend_i_q | pend_d_q;
    assign cand_i      = any_pend ? pend_i_q : accept_i;
    assign cand_d      = any_pend ? pend_d_q : accept_d;
    assign streak_full = (streak_q == SW'(MAX_STREAK));
    assign is_idle     = (state_q == StIdle);
    assign grant_i     = is_idle & cand_i & (~cand_d | streak_full);
    assign grant_d     = is_idle & cand_d & ~grant_i;
    assign direct_i    = grant_i & ~any_pend;
    assign direct_d    = grant_d & ~any_pend;

    assign sel_i_addr  = pend_i_q ? pend_i_addr_q  : imem_addr;
    assign sel_d_addr  = pend_d_q ? pend_d_addr_q  : dmem_addr;
    assign sel_d_wdata = pend_d_q ? pend_d_wdata_q : dmem_wdata;
    assign sel_d_wstrb = pend_d_q ? pend_d_wstrb_q : dmem_wstrb;

    // Pending buffers: capture accepted pulses unless granted straight through.
    always_comb begin
        pend_i_d       = pend_i_q;
        pend_i_addr_d  = pend_i_addr_q;
        pend_d_d       = pend_d_q;
        pend_d_addr_d  = pend_d_addr_q;
        pend_d_wdata_d = pend_d_wdata_q;
        pend_d_wstrb_d = pend_d_wstrb_q;
        if (grant_i) begin
            pend_i_d = 1'b0;
        end
        if (accept_i && !direct_i) begin
            pend_i_d      = 1'b1;
            pend_i_addr_d = imem_addr;
        end
        if (grant_d) begin
            pend_d_d = 1'b0;
        end
        if (accept_d && !direct_d) begin
            pend_d_d       = 1'b1;
            pend_d_addr_d  = dmem_addr;
            pend_d_wdata_d = dmem_wdata;
            pend_d_wstrb_d = dmem_wstrb;
        end
    end

    // Outstanding flags and the sticky protocol error.
    always_comb begin
        out_i_d = out_i_q;
        out_d_d = out_d_q;
        if (imem_ready) begin
            out_i_d = 1'b0;
        end
        if (accept_i) begin
            out_i_d = 1'b1;
        end
        if (dmem_ready) begin
            out_d_d = 1'b0;
        end
        if (accept_d) begin
            out_d_d = 1'b1;
        end
        proto_err_d = proto_err_q | drop_i | drop_d;
    end

    // Streak: data grants while a fetch waits; saturates at MAX_STREAK.
    always_comb begin
        streak_d = streak_q;
        if (grant_i || !pend_i_d) begin
            streak_d = '0;
        end else if (grant_d && !streak_full) begin
            streak_d = streak_q + SW'(1);
        end
    end

    // Next state and registered memory request.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = 1'b0;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        unique case (state_q)
            StIdle: begin
                if (grant_i) begin
                    state_d     = StBusyI;
                    mem_valid_d = 1'b1;
                    mem_instr_d = 1'b1;
                    mem_addr_d  = sel_i_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end else if (grant_d) begin
                    state_d     = StBusyD;
                    mem_valid_d = 1'b1;
                    mem_instr_d = 1'b0;
                    mem_addr_d  = sel_d_addr;
                    mem_wdata_d = sel_d_wdata;
                    mem_wstrb_d = sel_d_wstrb;
                end
            end
            StBusyI, StBusyD: begin
                if (mem_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; async reset drops any in-flight or buffered request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            pend_i_q       <= 1'b0;
            pend_i_addr_q  <= '0;
            pend_d_q       <= 1'b0;
            pend_d_addr_q  <= '0;
            pend_d_wdata_q <= '0;
            pend_d_wstrb_q <= '0;
            out_i_q        <= 1'b0;
            out_d_q        <= 1'b0;
            proto_err_q    <= 1'b0;
            streak_q       <= '0;
            mem_valid_q    <= 1'b0;
            mem_instr_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= '0;
        end else begin
            state_q        <= state_d;
            pend_i_q       <= pend_i_d;
            pend_i_addr_q  <= pend_i_addr_d;
            pend_d_q       <= pend_d_d;
            pend_d_addr_q  <= pend_d_addr_d;
            pend_d_wdata_q <= pend_d_wdata_d;
            pend_d_wstrb_q <= pend_d_wstrb_d;
            out_i_q        <= out_i_d;
            out_d_q        <= out_d_d;
            proto_err_q    <= proto_err_d;
            streak_q       <= streak_d;
            mem_valid_q    <= mem_valid_d;
            mem_instr_q    <= mem_instr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic; grants and
// responses are checked against a request-level model by a negedge monitor.
module tb_memory_arbiter;

    localparam int unsigned MAX_STREAK = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_valid, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_valid, mem_instr, mem_ready, proto_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    memory_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_i;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          c;
    } req_t;

    typedef struct {
        bit          is_i;
        logic [31:0] data;
    } resp_t;

    req_t  waitq[$];   // issued, not yet granted
    resp_t respq[$];   // responses the memory model has raised
    int    model_streak = 0;
    bit    infl_is_i;
    bit    mon_en = 1'b0;
    bit    mem_auto = 1'b1;
    int    mem_cnt = 0;
    int    fix_delay = 0;
    bit    fix_data_en = 1'b0;
    logic [31:0] fix_data = '0;
    bit    out_i = 1'b0, out_d = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: answers each request after 1..3 cycles.
    task automatic mem_tick();
        mem_ready = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = fix_data_en ? fix_data : $urandom;
                respq.push_back('{is_i: infl_is_i, data: mem_rdata});
            end
        end else if (mem_valid) begin
            mem_cnt = (fix_delay > 0) ? fix_delay : $urandom_range(1, 3);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (mem_auto) mem_tick();
        #1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    task automatic issue(bit is_i, logic [31:0] a, logic [31:0] w, logic [3:0] s, bit track);
        if (track) waitq.push_back('{is_i: is_i, addr: a, wdata: w, wstrb: s, c: cyc});
        if (is_i) begin
            imem_valid = 1'b1;
            imem_addr  = a;
        end else begin
            dmem_valid = 1'b1;
            dmem_addr  = a;
            dmem_wdata = w;
            dmem_wstrb = s;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        mem_ready = 1'b0;
        waitq.delete();
        respq.delete();
        model_streak = 0;
        mem_cnt = 0;
        out_i = 1'b0;
        out_d = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((waitq.size() != 0 || respq.size() != 0 || mem_cnt != 0 || mem_valid) && n < 100) begin
            step();
            n++;
        end
        out_i = 1'b0;
        out_d = 1'b0;
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain: traffic still active after %0d cycles, waiting %0d", n, waitq.size());
        end
    endtask

    // Model arbitration: buffered requests beat fresh ones; data beats fetch
    // unless MAX_STREAK data grants have already passed a waiting fetch.
    task automatic grant_check();
        int g = cyc;
        int idx_i = -1;
        int idx_d = -1;
        int pick;
        bit old = 1'b0;
        bit fetch_left = 1'b0;
        req_t e;
        foreach (waitq[k]) if (waitq[k].c <= g - 2) old = 1'b1;
        foreach (waitq[k]) begin
            if (waitq[k].c <= g - 1 && (!old || waitq[k].c <= g - 2)) begin
                if (waitq[k].is_i) idx_i = k;
                else idx_d = k;
            end
        end
        check("grant has eligible request", 32'(idx_i >= 0 || idx_d >= 0), 32'd1);
        if (idx_i < 0 && idx_d < 0) return;
        pick = (idx_i >= 0 && (idx_d < 0 || model_streak == MAX_STREAK)) ? idx_i : idx_d;
        e = waitq[pick];
        waitq.delete(pick);
        check("grant owner mem_instr", 32'(mem_instr), 32'(e.is_i));
        check("grant mem_addr", mem_addr, e.addr);
        check("grant mem_wstrb", 32'(mem_wstrb), e.is_i ? 32'd0 : 32'(e.wstrb));
        if (!e.is_i) check("grant mem_wdata", mem_wdata, e.wdata);
        infl_is_i = e.is_i;
        if (e.is_i) begin
            model_streak = 0;
        end else begin
            foreach (waitq[k]) if (waitq[k].is_i && waitq[k].c <= g - 1) fetch_left = 1'b1;
            model_streak = fetch_left ? ((model_streak < MAX_STREAK) ? model_streak + 1 : model_streak) : 0;
        end
    endtask

    task automatic resp_check();
        resp_t r;
        if (respq.size() == 0) begin
            if (imem_ready || dmem_ready) begin
                checks++;
                errors++;
                $display("FAIL resp: unexpected ready imem=%b dmem=%b (cycle %0d)", imem_ready, dmem_ready, cyc);
            end
        end else begin
            r = respq.pop_front();
            check("resp imem_ready", 32'(imem_ready), 32'(r.is_i));
            check("resp dmem_ready", 32'(dmem_ready), 32'(!r.is_i));
            check("resp rdata", r.is_i ? imem_rdata : dmem_rdata, r.data);
        end
    endtask

    // Monitor: checks every grant and response as the DUT presents it.
    always @(negedge clock) begin
        if (reset && mon_en) begin
            if (mem_valid) grant_check();
            resp_check();
            for (int k = waitq.size() - 1; k >= 0; k--) begin
                if (cyc - waitq[k].c > 60) begin
                    checks++;
                    errors++;
                    $display("FAIL starvation: request addr %h waited > 60 cycles", waitq[k].addr);
                    waitq.delete(k);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dgr;
        bit seen_i;
        reset = 1'b0;
        imem_valid = 1'b0; imem_addr = '0;
        dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #3;
        check("reset mem_valid", 32'(mem_valid), 32'd0);
        check("reset mem_instr", 32'(mem_instr), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("reset imem_ready", 32'(imem_ready), 32'd0);
        check("reset dmem_ready", 32'(dmem_ready), 32'd0);
        check("reset proto_err", 32'(proto_err), 32'd0);
        do_reset();
        mon_en = 1'b1;

        // Lone fetch: grant at T+1, reply two cycles later.
        fix_delay = 2; fix_data_en = 1'b1; fix_data = 32'h0000_0013;
        step();
        issue(1'b1, 32'h0000_0100, '0, '0, 1'b1);
        step();
        check("fetch latency mem_valid", 32'(mem_valid), 32'd1);
        check("fetch mem_instr", 32'(mem_instr), 32'd1);
        check("fetch mem_addr", mem_addr, 32'h0000_0100);
        step();
        check("mem_valid one cycle", 32'(mem_valid), 32'd0);
        check("fetch early imem_ready", 32'(imem_ready), 32'd0);
        step();
        check("fetch imem_ready", 32'(imem_ready), 32'd1);
        check("fetch imem_rdata", imem_rdata, 32'h0000_0013);
        check("fetch dmem_ready", 32'(dmem_ready), 32'd0);
        wait_idle();
        fix_delay = 0; fix_data_en = 1'b0;

        // Simultaneous fetch and store: store first, fetch after it completes.
        step();
        issue(1'b1, 32'h0000_0300, '0, '0, 1'b1);
        issue(1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 1'b1);
        step();
        check("store first mem_instr", 32'(mem_instr), 32'd0);
        check("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        n = 0;
        while (!dmem_ready && n < 20) begin step(); n++; end
        check("store response seen", 32'(dmem_ready), 32'd1);
        step();
        check("no grant in idle decision cycle", 32'(mem_valid), 32'd0);
        step();
        check("fetch after store mem_valid", 32'(mem_valid), 32'd1);
        check("fetch after store mem_instr", 32'(mem_instr), 32'd1);
        wait_idle();

        // Streak: data re-issued on every dmem_ready while a fetch waits.
        step();
        issue(1'b1, 32'h0000_0500, '0, '0, 1'b1);
        issue(1'b0, $urandom, $urandom, 4'($urandom), 1'b1);
        dgr = 0; seen_i = 1'b0; n = 0;
        while (!seen_i && n < 200) begin
            step();
            n++;
            if (mem_valid) begin
                if (mem_instr) seen_i = 1'b1;
                else dgr++;
            end
            if (dmem_ready && !seen_i) issue(1'b0, $urandom, $urandom, 4'($urandom), 1'b1);
        end
        check("data grants before fetch", 32'(dgr), 32'(MAX_STREAK));
        wait_idle();
        step();
        issue(1'b1, 32'h0000_0600, '0, '0, 1'b1);
        issue(1'b0, 32'h0000_0700, 32'h1, 4'b0001, 1'b1);
        step();
        check("streak cleared: data wins again", 32'(mem_instr), 32'd0);
        wait_idle();

        // Same-cycle reissue on imem_ready is legal.
        step();
        issue(1'b1, 32'h0000_0800, '0, '0, 1'b1);
        n = 0;
        while (!imem_ready && n < 20) begin step(); n++; end
        check("first fetch response", 32'(imem_ready), 32'd1);
        issue(1'b1, 32'h0000_0400, '0, '0, 1'b1);
        step();
        step();
        check("reissued fetch granted", 32'(mem_valid), 32'd1);
        check("reissued fetch addr", mem_addr, 32'h0000_0400);
        check("reissue no proto_err", 32'(proto_err), 32'd0);
        wait_idle();

        // Second data pulse while data outstanding: dropped, sticky error.
        step();
        issue(1'b0, 32'h0000_0900, 32'h5555_AAAA, 4'b0011, 1'b1);
        step();
        issue(1'b0, 32'h0000_0A00, 32'h0, 4'b1111, 1'b0);
        step();
        check("proto_err set", 32'(proto_err), 32'd1);
        wait_idle();
        repeat (3) step();
        check("proto_err sticky", 32'(proto_err), 32'd1);
        do_reset();
        check("proto_err cleared by reset", 32'(proto_err), 32'd0);

        // Reset during BUSY_D; a late mem_ready must be ignored.
        mem_auto = 1'b0;
        step();
        issue(1'b0, 32'h0000_3000, 32'h0000_1234, 4'b0011, 1'b1);
        step();
        check("busy_d grant", 32'(mem_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("async reset mem_valid", 32'(mem_valid), 32'd0);
        check("async reset mem_addr", mem_addr, 32'd0);
        check("async reset mem_wdata", mem_wdata, 32'd0);
        check("async reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        waitq.delete(); respq.delete(); model_streak = 0; mem_cnt = 0;
        step(); step();
        reset = 1'b1;
        step(); step();
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        check("stale mem_ready dmem_ready", 32'(dmem_ready), 32'd0);
        check("stale mem_ready imem_ready", 32'(imem_ready), 32'd0);
        step();
        mem_ready = 1'b0;
        check("no replay after reset", 32'(mem_valid), 32'd0);
        step();
        check("still no replay", 32'(mem_valid), 32'd0);
        mem_auto = 1'b1;

        // Randomized traffic, no protocol violations.
        for (int k = 0; k < 1500; k++) begin
            step();
            if (imem_ready) out_i = 1'b0;
            if (dmem_ready) out_d = 1'b0;
            if (!out_i && $urandom_range(0, 3) == 0) begin
                issue(1'b1, $urandom, '0, '0, 1'b1);
                out_i = 1'b1;
            end
            if (!out_d && $urandom_range(0, 2) == 0) begin
                issue(1'b0, $urandom, $urandom, 4'($urandom), 1'b1);
                out_d = 1'b1;
            end
        end
        wait_idle();
        check("random no proto_err", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
